// File: rtl/stream_pkg.sv
// Shared helpers for the stream width upsizer: lane-counter sizing and keep-mask generation.
package stream_pkg;

  localparam int MAX_RATIO = 16;

  // Counter width; a degenerate RATIO still yields a 1-bit counter so elaboration reaches the range check.
  function automatic int cnt_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic logic [MAX_RATIO-1:0] keep_mask(input int count, input int ratio);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_RATIO; i++) begin
      if (i <= count && i < ratio) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_packer.sv
// Packs RATIO WIDTH-bit beats into one word with keep mask; s_last flushes early. Latency 1 cycle.
// Backpressure: s_ready = !m_valid || m_ready; output register holds stable while stalled.
module stream_packer
  import stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH*RATIO-1:0]   m_data,
  output logic [RATIO-1:0]         m_keep,
  output logic                     m_last
);

  generate
    if (RATIO < 2 || RATIO > MAX_RATIO) begin : g_bad_ratio
      $error("stream_packer: RATIO must be in 2..16");
    end
  endgenerate

  localparam int            CW       = cnt_width(RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  logic [CW-1:0]          cnt;
  logic [WIDTH*RATIO-1:0] acc;
  logic [WIDTH*RATIO-1:0] word;
  logic [RATIO-1:0]       keep_nxt;
  logic                   accept;
  logic                   complete;

  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign complete = accept && (s_last || cnt == CNT_LAST);

  // Lanes above cnt are already zero because the accumulator is cleared on every completed word.
  always_comb begin
    word = acc;
    word[int'(cnt)*WIDTH +: WIDTH] = s_data;
    keep_nxt = RATIO'(keep_mask(int'(cnt), RATIO));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      acc     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (complete) begin
        m_data  <= word;
        m_keep  <= keep_nxt;
        m_last  <= s_last;
        m_valid <= 1'b1;
        acc     <= '0;
        cnt     <= '0;
      end else if (accept) begin
        acc <= word;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Bench for stream_packer (WIDTH=8, RATIO=4): vector table, directed corner sequences, random scoreboard.
module tb_stream_packer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   s_valid;
  logic                   s_ready;
  logic [WIDTH-1:0]       s_data;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [WIDTH*RATIO-1:0] m_data;
  logic [RATIO-1:0]       m_keep;
  logic                   m_last;

  int total = 0;
  int bad   = 0;

  stream_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_keep (m_keep),
    .m_last (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Reference packing: lane i holds the i-th beat of the word, keep has one bit per beat.
  function automatic word_t pack(input logic [7:0] beats[$], input logic last);
    word_t w;
    w.data = '0;
    for (int i = 0; i < beats.size(); i++) w.data[i*8 +: 8] = beats[i];
    w.keep = 4'((1 << beats.size()) - 1);
    w.last = last;
    return w;
  endfunction

  vec_t vecs[12];

  initial begin
    logic [7:0] part[$];
    word_t      exp_q[$];
    word_t      w;
    int         beats_in;
    int         words_out;
    int         cycles;
    int         stalls;

    vecs[0]  = '{1, 8'h11, 0, 0, 32'h0,        4'h0, 0};
    vecs[1]  = '{1, 8'h22, 0, 0, 32'h0,        4'h0, 0};
    vecs[2]  = '{1, 8'h33, 0, 0, 32'h0,        4'h0, 0};
    vecs[3]  = '{1, 8'h44, 0, 1, 32'h44332211, 4'hf, 0};
    vecs[4]  = '{1, 8'hAA, 0, 0, 32'h0,        4'h0, 0};
    vecs[5]  = '{1, 8'hBB, 1, 1, 32'h0000BBAA, 4'h3, 1};
    vecs[6]  = '{1, 8'h5C, 1, 1, 32'h0000005C, 4'h1, 1};
    vecs[7]  = '{1, 8'h01, 0, 0, 32'h0,        4'h0, 0};
    vecs[8]  = '{1, 8'h02, 0, 0, 32'h0,        4'h0, 0};
    vecs[9]  = '{1, 8'h03, 0, 0, 32'h0,        4'h0, 0};
    vecs[10] = '{1, 8'h04, 1, 1, 32'h04030201, 4'hf, 1};
    vecs[11] = '{0, 8'h00, 0, 0, 32'h0,        4'h0, 0};

    rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    step(); step();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data",  m_data,  0);
    check("rst_m_keep",  m_keep,  0);
    check("rst_m_last",  m_last,  0);
    check("rst_s_ready", s_ready, 1);
    rstn = 1'b1;
    step();

    // Vector table: streaming with m_ready held high.
    for (int i = 0; i < 12; i++) begin
      s_valid = vecs[i].v; s_data = vecs[i].d; s_last = vecs[i].l;
      check($sformatf("vec%0d_s_ready_pre", i), s_ready, 1);
      step();
      check($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_m_data", i), m_data, vecs[i].ed);
        check($sformatf("vec%0d_m_keep", i), m_keep, vecs[i].ek);
        check($sformatf("vec%0d_m_last", i), m_last, vecs[i].el);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;

    // Backpressure hold, then a single-beat word completing during the output handshake.
    m_ready = 1'b0;
    beat(8'hA1, 0); beat(8'hA2, 0); beat(8'hA3, 0); beat(8'hA4, 0);
    s_valid = 1'b1; s_data = 8'hB1; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_s_ready", i), s_ready, 0);
      check($sformatf("hold%0d_m_valid", i), m_valid, 1);
      check($sformatf("hold%0d_m_data", i),  m_data,  32'hA4A3A2A1);
      check($sformatf("hold%0d_m_keep", i),  m_keep,  4'hf);
      check($sformatf("hold%0d_m_last", i),  m_last,  0);
      step();
    end
    m_ready = 1'b1;
    #1;
    check("release_s_ready", s_ready, 1);
    step();
    s_valid = 1'b0; s_last = 1'b0;
    check("nogap_m_valid", m_valid, 1);
    check("nogap_m_data",  m_data,  32'h000000B1);
    check("nogap_m_keep",  m_keep,  4'h1);
    check("nogap_m_last",  m_last,  1);
    step();
    check("drain_m_valid", m_valid, 0);

    // Asynchronous reset mid-word, then while a word is pending.
    beat(8'hD1, 0); beat(8'hD2, 0);
    #2 rstn = 1'b0;
    #1 check("arst_mid_word_m_valid", m_valid, 0);
    @(negedge clk); rstn = 1'b1;
    m_ready = 1'b0;
    step();
    beat(8'hE1, 0); beat(8'hE2, 0); beat(8'hE3, 0); beat(8'hE4, 0);
    check("pend_m_valid", m_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_pend_m_valid", m_valid, 0);
    check("arst_pend_m_keep",  m_keep,  0);
    check("arst_pend_s_ready", s_ready, 1);
    @(negedge clk); rstn = 1'b1;
    m_ready = 1'b1;
    step();
    beat(8'hF1, 0); beat(8'hF2, 0); beat(8'hF3, 0); beat(8'hF4, 0);
    check("post_rst_m_valid", m_valid, 1);
    check("post_rst_m_data",  m_data,  32'hF4F3F2F1);
    check("post_rst_m_keep",  m_keep,  4'hf);
    step();

    // Throughput: 16 beats back-to-back with m_ready high must take 16 cycles, no stall.
    stalls = 0; words_out = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i); s_last = 1'b0;
      #1;
      if (!s_ready) stalls++;
      if (m_valid) words_out++;
      step();
    end
    s_valid = 1'b0;
    if (m_valid) words_out++;
    check("tput_stalls", stalls, 0);
    check("tput_words",  words_out, 4);
    step();

    // Random stream against a queue-based scoreboard.
    part.delete(); exp_q.delete();
    beats_in = 0; words_out = 0; cycles = 0;
    while ((beats_in < 64 || exp_q.size() != 0 || m_valid) && cycles < 3000) begin
      s_valid = (beats_in < 64) && ($urandom_range(3) != 0);
      s_data  = 8'($urandom);
      s_last  = (beats_in == 63) || ($urandom_range(5) == 0);
      m_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_word", 1, 0);
        end else begin
          w = exp_q.pop_front();
          words_out++;
          check($sformatf("rnd_w%0d_data", words_out), m_data, w.data);
          check($sformatf("rnd_w%0d_keep", words_out), m_keep, w.keep);
          check($sformatf("rnd_w%0d_last", words_out), m_last, w.last);
        end
      end
      if (s_valid && s_ready) begin
        beats_in++;
        part.push_back(s_data);
        if (s_last || part.size() == RATIO) begin
          exp_q.push_back(pack(part, s_last));
          part.delete();
        end
      end
      step();
      cycles++;
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    check("rnd_beats_in",   beats_in, 64);
    check("rnd_sb_empty",   exp_q.size(), 0);
    check("rnd_part_empty", part.size(), 0);
    check("rnd_timeout",    cycles < 3000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
